fifosc_wr_arb: RTL and testbench

- Write-side arbiter that shares one fifosc instance among NUM_REQ producers.
- Round-robin arbitration with a per-owner burst limit.
- Each accepted word is tagged with the producer ID, so the FIFO is instantiated with width ID_WIDTH+DATA_WIDTH.
- fifosc has no reset, so this block also sequences FIFO flushes: one on reset release, and one on request.

---
 rtl/fifosc_pkg.sv | 17 +
 rtl/rr_pick.sv | 24 ++
 rtl/fifosc_wr_arb.sv | 112 +++++++++++
 tb/tb_fifosc_wr_arb.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifosc_pkg.sv
// Shared types and helpers for the fifosc write-side arbiter and related schedulers.
package fifosc_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Circular priority pick: first set req bit scanning from start upward, wrapping.
module rr_pick #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] start,
    output logic                found,
    output logic [ID_WIDTH-1:0] idx
);

    // NOTE: defaults assigned first so every path drives found/idx and no latch is inferred.
    always_comb begin
        found = 1'b0;
        idx   = start;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[(int'(start) + k) % NUM_REQ]) begin
                found = 1'b1;
                idx   = ID_WIDTH'((int'(start) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/fifosc_wr_arb.sv
// Round-robin write arbiter sharing one fifosc among NUM_REQ producers, with burst
// limit, ID tagging and flush sequencing (fifosc itself has no reset).
module fifosc_wr_arb
    import fifosc_pkg::*;
#(
    parameter int  NUM_REQ    = 4,
    parameter int  DATA_WIDTH = 4,
    parameter int  BURST      = 2,
    localparam int ID_WIDTH   = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]             ack,
    input  logic                           flush_req,
    output logic                           busy,
    output logic                           fifo_insert,
    output logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_di,
    output logic                           fifo_flush,
    input  logic                           fifo_full,
    input  logic                           fifo_remove
);

    localparam int CNT_W = (clog2(BURST + 1) < 1) ? 1 : clog2(BURST + 1);

    state_t              state;
    logic [ID_WIDTH-1:0] last;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic [ID_WIDTH-1:0] start;
    logic [ID_WIDTH-1:0] scan_idx;
    logic [ID_WIDTH-1:0] winner;
    logic                scan_found;
    logic                keep;
    logic                space;
    logic                grant;

    assign start = (last == ID_WIDTH'(NUM_REQ - 1)) ? '0 : last + 1'b1;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_WIDTH(ID_WIDTH)
    ) u_pick (
        .req  (req),
        .start(start),
        .found(scan_found),
        .idx  (scan_idx)
    );

    // cnt==0 only after reset: the owner holds no claim yet, so arbitration starts at producer 0.
    assign keep   = req[last] && (cnt != '0) && (cnt < CNT_W'(BURST));
    assign winner = keep ? last : scan_idx;
    assign space  = ~fifo_full | fifo_remove;
    assign grant  = (state == ST_RUN) && !flush_req && (keep || scan_found) && space;

    always_comb begin
        ack = '0;
        if (grant) ack[winner] = 1'b1;
    end

    assign fifo_insert = grant;
    assign fifo_di     = grant ? {winner, req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH]} : '0;

    always_comb begin
        if (winner != last)               cnt_next = CNT_W'(1);
        else if (cnt == CNT_W'(BURST))    cnt_next = cnt;
        else                              cnt_next = cnt + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_INIT;
            fifo_flush <= 1'b1;
            busy       <= 1'b1;
            last       <= ID_WIDTH'(NUM_REQ - 1);
            cnt        <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    state      <= ST_RUN;
                    fifo_flush <= 1'b0;
                    busy       <= 1'b0;
                end
                ST_RUN: begin
                    if (flush_req) begin
                        state      <= ST_FLUSH;
                        fifo_flush <= 1'b1;
                        busy       <= 1'b1;
                    end else if (grant) begin
                        last <= winner;
                        cnt  <= cnt_next;
                    end
                end
                ST_FLUSH: begin
                    if (!flush_req) begin
                        state      <= ST_RUN;
                        fifo_flush <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_INIT;
                    fifo_flush <= 1'b1;
                    busy       <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifosc_wr_arb.sv
// Randomized and directed bench for fifosc_wr_arb against a behavioural arbiter
// model, with a queue standing in for the shared fifosc.
module tb_fifosc_wr_arb;

    localparam int N     = 4;
    localparam int DW    = 4;
    localparam int BURST = 2;
    localparam int IW    = 2;
    localparam int DEPTH = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic [N-1:0]      ack;
    logic              flush_req = 1'b0;
    logic              busy;
    logic              fifo_insert;
    logic [IW+DW-1:0]  fifo_di;
    logic              fifo_flush;
    logic              fifo_full = 1'b0;
    logic              fifo_remove = 1'b0;

    fifosc_wr_arb #(
        .NUM_REQ   (N),
        .DATA_WIDTH(DW),
        .BURST     (BURST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .flush_req  (flush_req),
        .busy       (busy),
        .fifo_insert(fifo_insert),
        .fifo_di    (fifo_di),
        .fifo_flush (fifo_flush),
        .fifo_full  (fifo_full),
        .fifo_remove(fifo_remove)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Producers, shared FIFO contents and the arbiter's abstract state.
    bit          p_req [N];
    logic [3:0]  p_data[N];
    logic [5:0]  q[$];
    logic [5:0]  last_pop;
    int          owner   = N - 1;
    int          run_len = 0;
    bit          m_init  = 1'b1;
    bit          m_flush = 1'b0;
    int          last_w  = -1;

    task automatic step();
        int         w;
        bit         g;
        logic [N-1:0] ea;
        logic [5:0] edi;
        logic [5:0] got_di;
        bit         got_ins;
        for (int i = 0; i < N; i++) begin
            req[i] = p_req[i];
            req_data[i*DW +: DW] = p_data[i];
        end
        fifo_full = (q.size() == DEPTH);
        if (q.size() == 0) fifo_remove = 1'b0;
        w = -1;
        if (!m_init && !m_flush && !flush_req && (!fifo_full || fifo_remove)) begin
            if (p_req[owner] && run_len > 0 && run_len < BURST) w = owner;
            else
                for (int k = 1; k <= N; k++)
                    if (w < 0 && p_req[(owner + k) % N]) w = (owner + k) % N;
        end
        g   = (w >= 0);
        ea  = '0;
        edi = '0;
        if (g) begin
            ea[w] = 1'b1;
            edi   = {2'(w), p_data[w]};
        end
        #1;
        check("ack", ack, ea);
        check("insert", fifo_insert, g);
        check("di", fifo_di, edi);
        check("busy", busy, m_init || m_flush);
        check("flush", fifo_flush, m_init || m_flush);
        got_di  = fifo_di;
        got_ins = fifo_insert;
        @(posedge clk);
        if (m_init || m_flush) q.delete();
        else begin
            if (fifo_remove) last_pop = q.pop_front();
            if (got_ins) q.push_back(got_di);
        end
        if (g) begin
            run_len = (w == owner) ? ((run_len < BURST) ? run_len + 1 : run_len) : 1;
            owner   = w;
        end
        if (m_init) m_init = 1'b0;
        else if (!m_flush && flush_req) m_flush = 1'b1;
        else if (m_flush && !flush_req) m_flush = 1'b0;
        last_w = g ? w : -1;
        #2;
    endtask

    task automatic drain();
        for (int i = 0; i < N; i++) p_req[i] = 1'b0;
        for (int k = 0; k < 20 && q.size() > 0; k++) begin
            fifo_remove = 1'b1;
            step();
        end
        check("drained", q.size(), 0);
    endtask

    int order[$];
    int exp_order[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    int acks;

    initial begin
        for (int i = 0; i < N; i++) begin
            p_req[i]  = 1'b0;
            p_data[i] = '0;
        end
        repeat (2) @(posedge clk);
        #2;
        check("rst_ack", ack, 0);
        check("rst_flush", fifo_flush, 1);
        check("rst_busy", busy, 1);
        rst = 1'b0;
        step();
        step();

        // All producers requesting, consumer draining every cycle.
        for (int i = 0; i < N; i++) begin
            p_req[i]  = 1'b1;
            p_data[i] = 4'(i + 1);
        end
        repeat (9) begin
            fifo_remove = 1'b1;
            step();
            order.push_back(last_w);
        end
        for (int i = 0; i < 9; i++) check("rr_order", order[i], exp_order[i]);
        drain();

        // Single producer fills the FIFO, then a concurrent remove lets one more in.
        p_req[2]  = 1'b1;
        p_data[2] = 4'h5;
        acks = 0;
        repeat (8) begin
            fifo_remove = 1'b0;
            step();
            if (last_w == 2) begin
                acks++;
                p_data[2] = p_data[2] + 1'b1;
            end
        end
        check("fill_acks", acks, 6);
        fifo_remove = 1'b1;
        step();
        check("full_concurrent_ack", last_w, 2);
        check("read_data", last_pop, 6'h25);
        drain();

        // Dropped requester forfeits; lone requester is granted back to back.
        p_req[1] = 1'b1;
        step();
        check("drop_ack1", last_w, 1);
        p_req[1] = 1'b0;
        p_req[3] = 1'b1;
        fifo_remove = 1'b1;
        step();
        check("next_ack3", last_w, 3);
        acks = 0;
        repeat (6) begin
            fifo_remove = 1'b1;
            step();
            if (last_w == 3) acks++;
        end
        check("lone_acks", acks, 6);
        drain();

        // Flush mid-burst; burst state survives.
        p_req[0] = 1'b1; p_data[0] = 4'h7;
        p_req[2] = 1'b1; p_data[2] = 4'h9;
        fifo_remove = 1'b1;
        step();
        check("pre_flush_ack0", last_w, 0);
        flush_req = 1'b1;
        step();
        step();
        flush_req = 1'b0;
        step();
        check("flush_empty", q.size(), 0);
        step();
        check("resume_owner", last_w, 0);
        step();
        check("resume_rotate", last_w, 2);
        drain();

        // Asynchronous reset while ack[0] is asserted.
        p_req[0] = 1'b1; p_data[0] = 4'hC;
        for (int i = 0; i < N; i++) begin
            req[i] = p_req[i];
            req_data[i*DW +: DW] = p_data[i];
        end
        fifo_full   = (q.size() == DEPTH);
        fifo_remove = 1'b0;
        #1;
        check("pre_rst_ack", ack, 4'b0001);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_ack", ack, 0);
        check("async_rst_insert", fifo_insert, 0);
        check("async_rst_flush", fifo_flush, 1);
        check("async_rst_busy", busy, 1);
        owner = N - 1; run_len = 0; m_init = 1'b1; m_flush = 1'b0;
        @(posedge clk);
        q.delete();
        @(posedge clk);
        q.delete();
        #2;
        rst = 1'b0;
        step();
        check("init_no_ack", last_w, -1);
        step();
        check("held_word_ack", last_w, 0);
        p_req[0] = 1'b0;
        step();
        check("no_duplicate", last_w, -1);
        drain();

        // Randomized traffic with occasional flushes and consumer stalls.
        repeat (400) begin
            flush_req = ($urandom_range(0, 19) == 0) || (m_flush && $urandom_range(0, 1) == 1);
            for (int i = 0; i < N; i++)
                if (!p_req[i] && $urandom_range(0, 2) == 0) begin
                    p_req[i]  = 1'b1;
                    p_data[i] = 4'($urandom_range(0, 15));
                end
            fifo_remove = ($urandom_range(0, 9) < 4);
            step();
            if (last_w >= 0) p_req[last_w] = 1'b0;
        end
        flush_req = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
